// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared types and default timing for the RTC bus sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package rtc_bus_pkg;

    localparam int CNT_W = 8;

    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_PULSE = 3;
    localparam int DEF_T_HOLD  = 1;
    localparam int DEF_T_GAP   = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STRB,
        A_HOLD,
        D_SETUP,
        D_STRB,
        D_HOLD,
        GAP
    } seq_state_e;

    function automatic logic is_addr_phase(seq_state_e s);
        return s inside {A_SETUP, A_STRB, A_HOLD};
    endfunction

    function automatic logic is_data_phase(seq_state_e s);
        return s inside {D_SETUP, D_STRB, D_HOLD};
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Host request/response and pad-block/RTC pin signals of the bus sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: busy masks start; requests arriving while busy are dropped.
interface rtc_bus_sequencer_if;

    // host side
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    // pad block and RTC strobes
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       bus_cap;
    logic [7:0] bus_in;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;

    // sequencer view
    modport slave (
        input  start, rw, addr, wdata, bus_in,
        output busy, done, rdata, bus_out, bus_oe, bus_cap, cs_n, rd_n, wr_n, a_d
    );

    // host / pad-block view
    modport master (
        output start, rw, addr, wdata, bus_in,
        input  busy, done, rdata, bus_out, bus_oe, bus_cap, cs_n, rd_n, wr_n, a_d
    );

endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable 8-bit down-counter that times each bus phase.
// Latency: load takes effect on the next clock; zero_o reflects the registered count.
// Backpressure: none; saturates at zero when neither loaded nor running.
module rtc_phase_timer
    import rtc_bus_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  cnt_t load_val_i,
    output cnt_t cnt_o,
    output logic zero_o,
    output logic next_zero_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // Load on phase entry, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign zero_o      = (cnt_q == '0);
    // Lets the owner register outputs that depend on "last cycle of this phase".
    assign next_zero_o = (cnt_d == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Turns host register requests into address+data phase cycles on the muxed RTC bus.
// Latency: 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP busy cycles, done in the following cycle.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int T_GAP   = DEF_T_GAP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rtc_bus_sequencer_if.slave    bus
);

    seq_state_e state_q, state_d;

    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       a_d_q, a_d_d;
    logic       bus_oe_q, bus_oe_d;
    logic       bus_cap_q, bus_cap_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;

    logic       tmr_load;
    cnt_t       tmr_load_val;
    cnt_t       tmr_cnt;
    logic       tmr_zero;
    logic       tmr_next_zero;

    // Counter reload value (length - 1) for the phase being entered.
    function automatic cnt_t phase_load(seq_state_e s);
        case (s)
            A_SETUP, D_SETUP: return cnt_t'(T_SETUP - 1);
            A_STRB,  D_STRB:  return cnt_t'(T_PULSE - 1);
            A_HOLD,  D_HOLD:  return cnt_t'(T_HOLD - 1);
            GAP:              return cnt_t'(T_GAP - 1);
            default:          return '0;
        endcase
    endfunction

    assign tmr_load     = (state_d != state_q);
    assign tmr_load_val = phase_load(state_d);

    rtc_phase_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (tmr_load),
        .load_val_i  (tmr_load_val),
        .cnt_o       (tmr_cnt),
        .zero_o      (tmr_zero),
        .next_zero_o (tmr_next_zero)
    );

    // Next state: accept in IDLE, then walk the phases as each count expires.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = A_SETUP;
                    rw_d    = bus.rw;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                end
            end
            A_SETUP: if (tmr_zero) state_d = A_STRB;
            A_STRB:  if (tmr_zero) state_d = A_HOLD;
            A_HOLD:  if (tmr_zero) state_d = D_SETUP;
            D_SETUP: if (tmr_zero) state_d = D_STRB;
            D_STRB:  if (tmr_zero) state_d = D_HOLD;
            D_HOLD:  if (tmr_zero) state_d = GAP;
            GAP:     if (tmr_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so every pin comes straight from a flop.
    always_comb begin
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        a_d_d     = 1'b0;
        bus_oe_d  = 1'b0;
        bus_cap_d = 1'b0;
        bus_out_d = bus_out_q;
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == GAP) && (state_d == IDLE);
        rdata_d   = rdata_q;

        // Address is always written, whatever the transaction direction.
        if (is_addr_phase(state_d)) begin
            cs_n_d    = 1'b0;
            bus_out_d = addr_d;
            bus_oe_d  = 1'b1;
            wr_n_d    = (state_d != A_STRB);
        end

        if (is_data_phase(state_d)) begin
            cs_n_d = 1'b0;
            a_d_d  = 1'b1;
            if (rw_d) begin
                // Pins released for the whole data phase so the RTC can drive them.
                rd_n_d    = (state_d != D_STRB);
                bus_cap_d = (state_d == D_STRB) && tmr_next_zero;
            end else begin
                bus_out_d = wdata_d;
                bus_oe_d  = 1'b1;
                wr_n_d    = (state_d != D_STRB);
            end
        end

        // Pad block registered the pins at the end of the strobe; take them in the first hold cycle.
        if ((state_q == D_HOLD) && rw_q && (tmr_cnt == cnt_t'(T_HOLD - 1))) begin
            rdata_d = bus.bus_in;
        end
    end

    // State, request latch and output registers; reset releases the pins immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            a_d_q     <= 1'b0;
            bus_oe_q  <= 1'b0;
            bus_cap_q <= 1'b0;
            bus_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            a_d_q     <= a_d_d;
            bus_oe_q  <= bus_oe_d;
            bus_cap_q <= bus_cap_d;
            bus_out_q <= bus_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.cs_n    = cs_n_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.wr_n    = wr_n_q;
    assign bus.a_d     = a_d_q;
    assign bus.bus_oe  = bus_oe_q;
    assign bus.bus_cap = bus_cap_q;
    assign bus.bus_out = bus_out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: default-timing instance plus a retimed one.
// Latency: n/a.
// Backpressure: n/a.
module tb_rtc_bus_sequencer;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] dat;
        logic       ad;
        logic [7:0] len;
        logic [7:0] aux;
    } ev_t;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    // Default timing: 2*(2+3+1)+2 busy cycles, 3-cycle strobes, 2-cycle gap.
    localparam int EXP_BUSY  = 14;
    localparam int EXP_PULSE = 3;
    localparam int EXP_GAP   = 2;

    // Retimed instance: 2*(4+1+2)+1 busy cycles.
    localparam int T2_SETUP  = 4;
    localparam int T2_PULSE  = 1;
    localparam int T2_HOLD   = 2;
    localparam int T2_GAP    = 1;
    localparam int EXP2_BUSY = 2 * (T2_SETUP + T2_PULSE + T2_HOLD) + T2_GAP;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] pin_val    = 8'h00;
    logic [7:0] pad_q      = 8'h00;
    logic [7:0] pad2_q     = 8'h00;
    logic [7:0] last_rdata = 8'h00;

    ev_t exp_q[$];

    always #5 clk = ~clk;

    rtc_bus_sequencer_if bif ();
    rtc_bus_sequencer_if bif2 ();

    rtc_bus_sequencer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    rtc_bus_sequencer #(
        .T_SETUP (T2_SETUP),
        .T_PULSE (T2_PULSE),
        .T_HOLD  (T2_HOLD),
        .T_GAP   (T2_GAP)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bif2)
    );

    // Pad-block models: register the pin value on a capture strobe.
    always @(posedge clk) begin
        if (bif.bus_cap)  pad_q  <= bif.rd_n  ? 8'h00 : pin_val;
        if (bif2.bus_cap) pad2_q <= bif2.rd_n ? 8'h00 : 8'hC3;
    end
    assign bif.bus_in  = pad_q;
    assign bif2.bus_in = pad2_q;

    function automatic ev_t mk_ev(logic [1:0] k, logic [7:0] d, logic ad, logic [7:0] len, logic [7:0] aux);
        return {k, d, ad, len, aux};
    endfunction

    task automatic push_exp(input logic rw, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rd_exp);
        exp_q.push_back(mk_ev(K_WR, a, 1'b0, 8'(EXP_PULSE), 8'h00));
        if (rw) exp_q.push_back(mk_ev(K_RD, 8'h00, 1'b1, 8'(EXP_PULSE), 8'h81));
        else    exp_q.push_back(mk_ev(K_WR, d, 1'b1, 8'(EXP_PULSE), 8'h00));
        exp_q.push_back(mk_ev(K_DONE, rd_exp, 1'b0, 8'(EXP_BUSY), 8'h00));
    endtask

    task automatic start_txn(input logic rw, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bif.start = 1'b1; bif.rw = rw; bif.addr = a; bif.wdata = d;
        @(posedge clk); #1;
        bif.start = 1'b0;
    endtask

    // Monitor on the default instance: turns strobe runs and done pulses into events.
    int         wr_run = 0, rd_run = 0, busy_run = 0, cap_in_run = 0;
    logic       last_cap = 1'b0, wr_ad = 1'b0, rd_ad = 1'b0, have_obs = 1'b0;
    logic [7:0] wr_dat = 8'h00;
    ev_t        obs, exp_e;

    always @(negedge clk) begin
        have_obs = 1'b0;
        if (!rst_n) begin
            wr_run = 0; rd_run = 0; busy_run = 0; cap_in_run = 0;
        end else begin
            checks++;
            if (!bif.rd_n && !bif.wr_n) begin
                errors++; $display("FAIL strobe_overlap rd_n=%b wr_n=%b, required not both low", bif.rd_n, bif.wr_n);
            end
            checks++;
            if (bif.bus_oe && !bif.rd_n) begin
                errors++; $display("FAIL oe_during_read bus_oe=%b rd_n=%b, required bus_oe=0", bif.bus_oe, bif.rd_n);
            end
            checks++;
            if (bif.bus_cap && bif.rd_n) begin
                errors++; $display("FAIL cap_outside_read bus_cap=1 rd_n=1, required bus_cap=0");
            end

            if (!bif.wr_n) begin
                if (wr_run == 0) begin wr_dat = bif.bus_out; wr_ad = bif.a_d; end
                wr_run++;
            end else if (wr_run != 0) begin
                obs = mk_ev(K_WR, wr_dat, wr_ad, 8'(wr_run), 8'h00);
                have_obs = 1'b1; wr_run = 0;
            end

            if (!bif.rd_n) begin
                if (rd_run == 0) begin rd_ad = bif.a_d; cap_in_run = 0; end
                rd_run++;
                if (bif.bus_cap) cap_in_run++;
                last_cap = bif.bus_cap;
            end else if (rd_run != 0) begin
                obs = mk_ev(K_RD, 8'h00, rd_ad, 8'(rd_run), {last_cap, 7'(cap_in_run)});
                have_obs = 1'b1; rd_run = 0;
            end

            if (bif.done) begin
                obs = mk_ev(K_DONE, bif.rdata, bif.busy, 8'(busy_run), 8'h00);
                have_obs = 1'b1;
            end
            if (bif.busy) busy_run++;
            else          busy_run = 0;

            if (have_obs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb_unexpected got=%h, required no event", obs);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (obs !== exp_e) begin
                        errors++; $display("FAIL sb_event got=%h required=%h", obs, exp_e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        checks++; if (bif.cs_n !== 1'b1)    begin errors++; $display("FAIL rst_cs_n got=%b required=1", bif.cs_n); end
        checks++; if (bif.rd_n !== 1'b1)    begin errors++; $display("FAIL rst_rd_n got=%b required=1", bif.rd_n); end
        checks++; if (bif.wr_n !== 1'b1)    begin errors++; $display("FAIL rst_wr_n got=%b required=1", bif.wr_n); end
        checks++; if (bif.bus_oe !== 1'b0)  begin errors++; $display("FAIL rst_bus_oe got=%b required=0", bif.bus_oe); end
        checks++; if (bif.bus_cap !== 1'b0) begin errors++; $display("FAIL rst_bus_cap got=%b required=0", bif.bus_cap); end
        checks++; if (bif.a_d !== 1'b0)     begin errors++; $display("FAIL rst_a_d got=%b required=0", bif.a_d); end
        checks++; if (bif.busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got=%b required=0", bif.busy); end
        checks++; if (bif.done !== 1'b0)    begin errors++; $display("FAIL rst_done got=%b required=0", bif.done); end
        checks++; if (bif.bus_out !== 8'h00) begin errors++; $display("FAIL rst_bus_out got=%h required=00", bif.bus_out); end
        checks++; if (bif.rdata !== 8'h00)  begin errors++; $display("FAIL rst_rdata got=%h required=00", bif.rdata); end
        @(negedge clk);
        rst_n = 1'b1; rst2_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bif.busy !== 1'b0 || bif.cs_n !== 1'b1) begin
            errors++; $display("FAIL idle_after_rst busy=%b cs_n=%b required busy=0 cs_n=1", bif.busy, bif.cs_n);
        end
    endtask

    task automatic test_write();
        int n = 0;
        push_exp(1'b0, 8'h21, 8'h47, last_rdata);
        start_txn(1'b0, 8'h21, 8'h47);
        checks++; if (bif.busy !== 1'b1 || bif.cs_n !== 1'b0 || bif.bus_out !== 8'h21) begin
            errors++; $display("FAIL write_first_cycle busy=%b cs_n=%b bus_out=%h required 1/0/21", bif.busy, bif.cs_n, bif.bus_out);
        end
        do begin @(negedge clk); n++; end while (!bif.done && n < 200);
        checks++; if (bif.done !== 1'b1) begin errors++; $display("FAIL write_timeout done=%b after %0d cycles, required 1", bif.done, n); end
        checks++; if (bif.rdata !== last_rdata) begin errors++; $display("FAIL write_rdata got=%h required=%h", bif.rdata, last_rdata); end
        @(posedge clk); #1;
        checks++; if (bif.done !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL write_end done=%b pending=%0d required 0/0", bif.done, exp_q.size());
        end
    endtask

    task automatic test_read();
        int n = 0;
        int oe_bad = 0;
        pin_val = 8'h5A;
        push_exp(1'b1, 8'h23, 8'h00, 8'h5A);
        start_txn(1'b1, 8'h23, 8'h00);
        do begin
            @(negedge clk);
            if (bif.a_d && bif.bus_oe) oe_bad++;
            n++;
        end while (!bif.done && n < 200);
        checks++; if (bif.done !== 1'b1) begin errors++; $display("FAIL read_timeout done=%b after %0d cycles, required 1", bif.done, n); end
        checks++; if (oe_bad != 0) begin errors++; $display("FAIL read_data_oe got %0d cycles with bus_oe=1, required 0", oe_bad); end
        checks++; if (bif.rdata !== 8'h5A) begin errors++; $display("FAIL read_rdata got=%h required=5a", bif.rdata); end
        last_rdata = 8'h5A;
        @(posedge clk); #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL read_pending got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        push_exp(1'b0, 8'h30, 8'h31, last_rdata);
        start_txn(1'b0, 8'h30, 8'h31);
        repeat (4) @(posedge clk);
        #1;
        bif.start = 1'b1; bif.rw = 1'b1; bif.addr = 8'h99;
        @(posedge clk); #1;
        bif.start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bif.done) dones++;
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL ignored_done_count got=%0d required=1", dones); end
        checks++; if (bif.busy !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL ignored_end busy=%b pending=%0d required 0/0", bif.busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int gap1 = 0;
        int gap2 = 0;
        push_exp(1'b0, 8'h40, 8'h41, last_rdata);
        push_exp(1'b0, 8'h40, 8'h41, last_rdata);
        @(posedge clk); #1;
        bif.start = 1'b1; bif.rw = 1'b0; bif.addr = 8'h40; bif.wdata = 8'h41;
        do begin
            @(negedge clk);
            if (bif.busy && bif.cs_n) gap1++;
            n++;
        end while (!bif.done && n < 200);
        checks++; if (bif.done !== 1'b1 || bif.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_first_done done=%b busy=%b required 1/0", bif.done, bif.busy);
        end
        @(posedge clk); #1;
        bif.start = 1'b0;
        checks++; if (bif.busy !== 1'b1 || bif.cs_n !== 1'b0) begin
            errors++; $display("FAIL b2b_second_start busy=%b cs_n=%b required 1/0", bif.busy, bif.cs_n);
        end
        n = 0;
        do begin
            @(negedge clk);
            if (bif.busy && bif.cs_n) gap2++;
            n++;
        end while (!bif.done && n < 200);
        checks++; if (bif.done !== 1'b1) begin errors++; $display("FAIL b2b_timeout done=%b required 1", bif.done); end
        checks++; if (gap1 != EXP_GAP || gap2 != EXP_GAP) begin
            errors++; $display("FAIL b2b_gap got=%0d,%0d required=%0d", gap1, gap2, EXP_GAP);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (bif.busy !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_end busy=%b pending=%0d required 0/0", bif.busy, exp_q.size());
        end
    endtask

    task automatic test_reset_midop();
        int n = 0;
        int dones = 0;
        int busys = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_q.delete();
        last_rdata = 8'h00;
        pin_val = 8'h5A;
        exp_q.push_back(mk_ev(K_WR, 8'h23, 1'b0, 8'(EXP_PULSE), 8'h00));
        start_txn(1'b1, 8'h23, 8'h00);
        do begin @(negedge clk); n++; end while (bif.rd_n && n < 200);
        checks++; if (bif.rd_n !== 1'b0) begin errors++; $display("FAIL midop_no_strobe rd_n=%b required 0", bif.rd_n); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bif.cs_n !== 1'b1 || bif.rd_n !== 1'b1 || bif.wr_n !== 1'b1) begin
            errors++; $display("FAIL midop_strobes cs_n=%b rd_n=%b wr_n=%b required 1/1/1", bif.cs_n, bif.rd_n, bif.wr_n);
        end
        checks++; if (bif.bus_oe !== 1'b0 || bif.busy !== 1'b0 || bif.done !== 1'b0) begin
            errors++; $display("FAIL midop_ctrl bus_oe=%b busy=%b done=%b required 0/0/0", bif.bus_oe, bif.busy, bif.done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bif.done) dones++;
            if (bif.busy) busys++;
        end
        checks++; if (dones != 0 || busys != 0) begin
            errors++; $display("FAIL midop_after done_cycles=%0d busy_cycles=%0d required 0/0", dones, busys);
        end
        checks++; if (bif.rdata !== last_rdata) begin errors++; $display("FAIL midop_rdata got=%h required=%h", bif.rdata, last_rdata); end
    endtask

    task automatic test_timing_params();
        int n = 0, busy_cnt = 0, rd_lo = 0, wr_lo = 0, wr_falls = 0, cap_cnt = 0, cap_co = 0;
        logic prev_wr = 1'b1;
        for (int t = 0; t < 2; t++) begin
            n = 0; busy_cnt = 0; rd_lo = 0; wr_lo = 0; wr_falls = 0; cap_cnt = 0; cap_co = 0; prev_wr = 1'b1;
            @(posedge clk); #1;
            bif2.start = 1'b1; bif2.rw = (t == 0); bif2.addr = 8'h55; bif2.wdata = 8'h66;
            @(posedge clk); #1;
            bif2.start = 1'b0;
            do begin
                @(negedge clk);
                if (bif2.busy) busy_cnt++;
                if (!bif2.rd_n) rd_lo++;
                if (!bif2.wr_n) wr_lo++;
                if (!bif2.wr_n && prev_wr) wr_falls++;
                prev_wr = bif2.wr_n;
                if (bif2.bus_cap) cap_cnt++;
                if (bif2.bus_cap && !bif2.rd_n) cap_co++;
                n++;
            end while (!bif2.done && n < 200);
            checks++; if (busy_cnt != EXP2_BUSY) begin errors++; $display("FAIL t2_busy[%0d] got=%0d required=%0d", t, busy_cnt, EXP2_BUSY); end
            if (t == 0) begin
                checks++; if (rd_lo != 1 || wr_lo != 1) begin
                    errors++; $display("FAIL t2_read_strobes rd_low=%0d wr_low=%0d required 1/1", rd_lo, wr_lo);
                end
                checks++; if (cap_cnt != 1 || cap_co != 1) begin
                    errors++; $display("FAIL t2_cap cap=%0d coincident=%0d required 1/1", cap_cnt, cap_co);
                end
                checks++; if (bif2.rdata !== 8'hC3) begin errors++; $display("FAIL t2_rdata got=%h required=c3", bif2.rdata); end
            end else begin
                checks++; if (wr_lo != 2 || wr_falls != 2 || rd_lo != 0 || cap_cnt != 0) begin
                    errors++; $display("FAIL t2_write_strobes wr_low=%0d falls=%0d rd_low=%0d cap=%0d required 2/2/0/0", wr_lo, wr_falls, rd_lo, cap_cnt);
                end
                checks++; if (bif2.rdata !== 8'hC3) begin errors++; $display("FAIL t2_write_rdata got=%h required=c3", bif2.rdata); end
            end
        end
    endtask

    initial begin
        bif.start  = 1'b0; bif.rw  = 1'b0; bif.addr  = 8'h00; bif.wdata  = 8'h00;
        bif2.start = 1'b0; bif2.rw = 1'b0; bif2.addr = 8'h00; bif2.wdata = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_start_ignored();
        test_back_to_back();
        test_reset_midop();
        test_timing_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
